// File: rtl/accumulator_writeback_unit.sv
// Drains accumulator rows through ReLU/shift/saturate requantisation into packed
// ACT_W lanes and writes them to the unified buffer via a 2-entry holding FIFO.
module accumulator_writeback_unit #(
    parameter int MUL_SIZE   = 16,
    parameter int ACC_W      = 32,
    parameter int ACT_W      = 8,
    parameter int ACC_ADDR_W = 7,
    parameter int UB_ADDR_W  = 12
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [8:0]                  rows_i,
    input  logic [ACC_ADDR_W-1:0]       acc_start_addr_i,
    input  logic [UB_ADDR_W-1:0]        ub_start_addr_wr_i,
    input  logic                        relu_en_i,
    input  logic [4:0]                  shift_i,
    input  logic [MUL_SIZE*ACC_W-1:0]   accumulator_data_i,
    input  logic                        ub_wr_ready_i,
    output logic                        read_accumulator_o,
    output logic [ACC_ADDR_W-1:0]       accumulator_addr_rd_o,
    output logic                        ub_wr_en_o,
    output logic [UB_ADDR_W-1:0]        ub_addr_wr_o,
    output logic [MUL_SIZE*ACT_W-1:0]   ub_data_wr_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o
);

    localparam logic [9:0] ACC_DEPTH = 10'(1 << ACC_ADDR_W);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (ACT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (ACT_W-1)));

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    state_t                      state;
    logic [8:0]                  rows_cfg;
    logic [8:0]                  issued;
    logic [8:0]                  written;
    logic [ACC_ADDR_W-1:0]       acc_start;
    logic [UB_ADDR_W-1:0]        ub_start;
    logic                        relu_en;
    logic [4:0]                  shift;
    logic                        inflight;
    logic                        error_flag;
    logic [1:0]                  occ;
    logic [MUL_SIZE*ACT_W-1:0]   fifo_mem [2];

    logic                        pop;
    logic                        push;
    logic [1:0]                  occ_after_pop;
    logic [1:0]                  slots;
    logic [1:0]                  occ_next;
    logic [MUL_SIZE*ACT_W-1:0]   packed_row;

    // Per-lane requantisation, applied as rows enter the FIFO.
    for (genvar gi = 0; gi < MUL_SIZE; gi++) begin : g_lane
        logic signed [ACC_W-1:0] x;
        logic signed [ACC_W-1:0] y;
        logic [ACT_W-1:0]        lane;
        always_comb begin
            x = accumulator_data_i[gi*ACC_W +: ACC_W];
            if (relu_en && x[ACC_W-1]) x = '0;
            y = x >>> shift;
            if (y > SAT_MAX)      lane = SAT_MAX[ACT_W-1:0];
            else if (y < SAT_MIN) lane = SAT_MIN[ACT_W-1:0];
            else                  lane = y[ACT_W-1:0];
        end
        assign packed_row[gi*ACT_W +: ACT_W] = lane;
    end

    assign ub_wr_en_o    = (occ != 2'd0);
    assign pop           = ub_wr_en_o & ub_wr_ready_i;
    assign push          = inflight;
    assign occ_after_pop = occ - {1'b0, pop};
    assign slots         = occ_after_pop + {1'b0, inflight};
    assign occ_next      = occ_after_pop + {1'b0, push};

    // A slot freed by this cycle's pop can be refilled, which keeps 1 row/cycle.
    assign read_accumulator_o    = (state == DRAIN) && (slots < 2'd2);
    assign accumulator_addr_rd_o = acc_start + ACC_ADDR_W'(issued);
    assign ub_addr_wr_o          = ub_start + UB_ADDR_W'(written);
    assign ub_data_wr_o          = fifo_mem[0];
    assign busy_o                = (state == DRAIN) || (state == FLUSH);
    assign done_o                = (state == DONE);
    assign error_o               = error_flag;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rows_cfg    <= '0;
            issued      <= '0;
            written     <= '0;
            acc_start   <= '0;
            ub_start    <= '0;
            relu_en     <= 1'b0;
            shift       <= '0;
            inflight    <= 1'b0;
            error_flag  <= 1'b0;
            occ         <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            inflight <= read_accumulator_o;
            occ      <= occ_next;
            if (read_accumulator_o) issued <= issued + 9'd1;
            if (pop) begin
                written     <= written + 9'd1;
                fifo_mem[0] <= fifo_mem[1];
            end
            if (push) fifo_mem[occ_after_pop[0]] <= packed_row;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        rows_cfg   <= rows_i;
                        acc_start  <= acc_start_addr_i;
                        ub_start   <= ub_start_addr_wr_i;
                        relu_en    <= relu_en_i;
                        shift      <= shift_i;
                        issued     <= '0;
                        written    <= '0;
                        error_flag <= ({1'b0, rows_i} > ACC_DEPTH);
                        if (rows_i == 9'd0 || {1'b0, rows_i} > ACC_DEPTH) state <= DONE;
                        else                                               state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (read_accumulator_o && (issued + 9'd1 == rows_cfg)) state <= FLUSH;
                end
                FLUSH: begin
                    // No reads are issued here, so an empty next FIFO means nothing in flight.
                    if (occ_next == 2'd0) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_writeback_unit.sv
// Self-checking bench for accumulator_writeback_unit: vector table for lane math,
// randomized drains against a queue-based reference model, and corner sequences.
module tb_accumulator_writeback_unit;

    localparam int MUL_SIZE   = 16;
    localparam int ACC_W      = 32;
    localparam int ACT_W      = 8;
    localparam int ACC_ADDR_W = 7;
    localparam int UB_ADDR_W  = 12;
    localparam int DEPTH      = 1 << ACC_ADDR_W;
    localparam int UB_DEPTH   = 1 << UB_ADDR_W;

    logic                        clk = 1'b0;
    logic                        rst_i = 1'b1;
    logic                        start_i = 1'b0;
    logic [8:0]                  rows_i = '0;
    logic [ACC_ADDR_W-1:0]       acc_start_addr_i = '0;
    logic [UB_ADDR_W-1:0]        ub_start_addr_wr_i = '0;
    logic                        relu_en_i = 1'b0;
    logic [4:0]                  shift_i = '0;
    logic [MUL_SIZE*ACC_W-1:0]   accumulator_data_i = '0;
    logic                        ub_wr_ready_i = 1'b1;
    logic                        read_accumulator_o;
    logic [ACC_ADDR_W-1:0]       accumulator_addr_rd_o;
    logic                        ub_wr_en_o;
    logic [UB_ADDR_W-1:0]        ub_addr_wr_o;
    logic [MUL_SIZE*ACT_W-1:0]   ub_data_wr_o;
    logic                        busy_o;
    logic                        done_o;
    logic                        error_o;

    accumulator_writeback_unit dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .start_i               (start_i),
        .rows_i                (rows_i),
        .acc_start_addr_i      (acc_start_addr_i),
        .ub_start_addr_wr_i    (ub_start_addr_wr_i),
        .relu_en_i             (relu_en_i),
        .shift_i               (shift_i),
        .accumulator_data_i    (accumulator_data_i),
        .ub_wr_ready_i         (ub_wr_ready_i),
        .read_accumulator_o    (read_accumulator_o),
        .accumulator_addr_rd_o (accumulator_addr_rd_o),
        .ub_wr_en_o            (ub_wr_en_o),
        .ub_addr_wr_o          (ub_addr_wr_o),
        .ub_data_wr_o          (ub_data_wr_o),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .error_o               (error_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [MUL_SIZE*ACC_W-1:0] acc_mem [DEPTH];
    int                        exp_rd [$];
    int                        exp_wa [$];
    logic [MUL_SIZE*ACT_W-1:0] exp_wd [$];

    bit  mon_en = 1'b0;
    int  ready_mode = 0;
    int  strobes = 0, writes = 0, first_strobe = -1, first_wr = -1, last_wr = -1;
    bit  rd_pend = 1'b0;
    int  rd_addr_pend = 0;
    bit  prev_stall = 1'b0;
    logic [UB_ADDR_W-1:0]      prev_addr;
    logic [MUL_SIZE*ACT_W-1:0] prev_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [127:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event, value %0h (cycle %0d)", name, act, cyc);
    endtask

    // Reference lane: floor division by 2**sh, then clamp to the signed ACT_W range.
    function automatic logic [ACT_W-1:0] ref_lane(input longint x, input bit relu, input int sh);
        longint v, d, q;
        v = x;
        if (relu && v < 0) v = 0;
        d = 1;
        d = d << sh;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        if (q > (1 << (ACT_W-1)) - 1) q = (1 << (ACT_W-1)) - 1;
        if (q < -(1 << (ACT_W-1)))    q = -(1 << (ACT_W-1));
        return q[ACT_W-1:0];
    endfunction

    task automatic build_expect(input int acc_s, input int ub_s, input int rows, input bit relu, input int sh);
        logic [MUL_SIZE*ACT_W-1:0] row;
        for (int k = 0; k < rows; k++) begin
            int a;
            a = (acc_s + k) % DEPTH;
            for (int l = 0; l < MUL_SIZE; l++) begin
                logic signed [ACC_W-1:0] lv;
                lv = acc_mem[a][l*ACC_W +: ACC_W];
                row[l*ACT_W +: ACT_W] = ref_lane(longint'(lv), relu, sh);
            end
            exp_rd.push_back(a);
            exp_wa.push_back((ub_s + k) % UB_DEPTH);
            exp_wd.push_back(row);
        end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < DEPTH; r++) begin
            for (int l = 0; l < MUL_SIZE; l++) begin
                case ($urandom_range(0, 3))
                    0:       acc_mem[r][l*ACC_W +: ACC_W] = 32'($urandom_range(0, 800)) - 32'd400;
                    1:       acc_mem[r][l*ACC_W +: ACC_W] = 32'($urandom_range(0, 200)) - 32'd100;
                    default: acc_mem[r][l*ACC_W +: ACC_W] = $urandom();
                endcase
            end
        end
    endtask

    always @(posedge clk) cyc++;

    // Accumulator model returns row data one cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
        #1;
        ub_wr_ready_i = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (rd_pend) accumulator_data_i = acc_mem[rd_addr_pend];
        else for (int l = 0; l < MUL_SIZE; l++) accumulator_data_i[l*ACC_W +: ACC_W] = $urandom();
    end

    always @(negedge clk) begin
        rd_pend      = read_accumulator_o;
        rd_addr_pend = int'(accumulator_addr_rd_o);
        if (mon_en) begin
            if (prev_stall) begin
                chk("stall_en_held", ub_wr_en_o, 1'b1);
                chk("stall_addr_stable", ub_addr_wr_o, prev_addr);
                chk("stall_data_stable", ub_data_wr_o, prev_data);
            end
            if (read_accumulator_o) begin
                chk("outstanding_le_2", (strobes - writes) <= 2, 1'b1);
                if (exp_rd.size() == 0) flag("extra_strobe", accumulator_addr_rd_o);
                else chk("rd_addr", accumulator_addr_rd_o, exp_rd.pop_front());
                if (first_strobe < 0) first_strobe = cyc;
                strobes++;
            end
            if (ub_wr_en_o && ub_wr_ready_i) begin
                if (exp_wd.size() == 0) flag("extra_write", ub_addr_wr_o);
                else begin
                    chk("wr_addr", ub_addr_wr_o, exp_wa.pop_front());
                    chk("wr_data", ub_data_wr_o, exp_wd.pop_front());
                end
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                writes++;
                $display("write %0d: addr=%03h data=%032h cycle=%0d", writes, ub_addr_wr_o, ub_data_wr_o, cyc);
            end
            prev_stall = ub_wr_en_o && !ub_wr_ready_i;
            prev_addr  = ub_addr_wr_o;
            prev_data  = ub_data_wr_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run(input int acc_s, input int ub_s, input int rows, input bit relu,
                       input int sh, input bit poke);
        int  s_cyc, done_cyc, n_exp;
        bit  got;
        n_exp = (rows <= DEPTH) ? rows : 0;
        strobes = 0; writes = 0; first_strobe = -1; first_wr = -1; last_wr = -1;
        @(negedge clk);
        start_i = 1'b1;
        rows_i = 9'(rows);
        acc_start_addr_i = ACC_ADDR_W'(acc_s);
        ub_start_addr_wr_i = UB_ADDR_W'(ub_s);
        relu_en_i = relu;
        shift_i = 5'(sh);
        s_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
        rows_i = 9'($urandom());
        acc_start_addr_i = ACC_ADDR_W'($urandom());
        ub_start_addr_wr_i = UB_ADDR_W'($urandom());
        relu_en_i = 1'($urandom());
        shift_i = 5'($urandom());
        got = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (done_o) begin
                got = 1'b1;
                done_cyc = cyc;
            end else begin
                if (poke && i == 2) begin
                    start_i = 1'b1; rows_i = 9'd3;
                    acc_start_addr_i = 7'd50; ub_start_addr_wr_i = 12'h555;
                end
                if (poke && i == 3) start_i = 1'b0;
                @(negedge clk);
            end
        end
        chk("done_seen", got, 1'b1);
        if (got) begin
            if (n_exp == 0) chk("done_next_cycle", done_cyc, s_cyc + 1);
            else            chk("done_after_last_write", done_cyc, last_wr + 1);
            chk("busy_at_done", busy_o, 1'b0);
            chk("error_flag", error_o, rows > DEPTH);
            if (ready_mode == 0 && n_exp > 0) begin
                chk("first_write_latency", first_wr - first_strobe, 2);
                chk("back_to_back_writes", done_cyc - first_wr, rows);
            end
            @(negedge clk);
            chk("done_pulse_width", done_o, 1'b0);
            chk("busy_after_done", busy_o, 1'b0);
        end
        chk("write_count", writes, n_exp);
        chk("strobe_count", strobes, n_exp);
        chk("scoreboard_drained", exp_wd.size() + exp_rd.size(), 0);
        $display("run acc=%0d ub=%03h rows=%0d relu=%0d shift=%0d: %0d writes", acc_s, ub_s, rows, relu, sh, writes);
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        @(negedge clk);
    endtask

    typedef struct {
        int          val;
        bit          relu;
        int          sh;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[14];

    initial begin
        int wait_n, stray;
        vecs[0]  = '{300,         1'b0, 0,  8'h7F};
        vecs[1]  = '{-300,        1'b0, 0,  8'h80};
        vecs[2]  = '{-5,          1'b0, 0,  8'hFB};
        vecs[3]  = '{300,         1'b1, 0,  8'h7F};
        vecs[4]  = '{-300,        1'b1, 0,  8'h00};
        vecs[5]  = '{-5,          1'b1, 0,  8'h00};
        vecs[6]  = '{300,         1'b0, 4,  8'h12};
        vecs[7]  = '{-300,        1'b0, 4,  8'hED};
        vecs[8]  = '{127,         1'b0, 0,  8'h7F};
        vecs[9]  = '{128,         1'b0, 0,  8'h7F};
        vecs[10] = '{-128,        1'b0, 0,  8'h80};
        vecs[11] = '{-129,        1'b0, 0,  8'h80};
        vecs[12] = '{-1,          1'b0, 31, 8'hFF};
        vecs[13] = '{2147483647,  1'b0, 24, 8'h7F};

        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_read_strobe", read_accumulator_o, 1'b0);
        chk("rst_acc_addr", accumulator_addr_rd_o, 0);
        chk("rst_wr_en", ub_wr_en_o, 1'b0);
        chk("rst_ub_addr", ub_addr_wr_o, 0);
        chk("rst_ub_data", ub_data_wr_o, 0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        mon_en = 1'b1;

        // Lane-math vectors: every lane of row 0 carries the vector value.
        for (int i = 0; i < 14; i++) begin
            logic [ACT_W-1:0] e;
            e = vecs[i].exp;
            for (int l = 0; l < MUL_SIZE; l++) acc_mem[0][l*ACC_W +: ACC_W] = vecs[i].val;
            exp_rd.push_back(0);
            exp_wa.push_back(16'h100 + i);
            exp_wd.push_back({MUL_SIZE{e}});
            run(0, 16'h100 + i, 1, vecs[i].relu, vecs[i].sh, 1'b0);
        end

        // Basic drain: four rows of 5s.
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < MUL_SIZE; l++) acc_mem[r][l*ACC_W +: ACC_W] = 5;
        build_expect(0, 12'h100, 4, 1'b0, 0);
        run(0, 12'h100, 4, 1'b0, 0, 1'b0);

        fill_rand();
        ready_mode = 1;
        build_expect(10, 12'h200, 8, 1'b0, 0);
        run(10, 12'h200, 8, 1'b0, 0, 1'b0);

        ready_mode = 0;
        build_expect(126, 12'hFFE, 4, 1'b1, 2);
        run(126, 12'hFFE, 4, 1'b1, 2, 1'b0);

        run(5, 12'h010, 0, 1'b0, 0, 1'b0);
        run(5, 12'h010, 200, 1'b0, 0, 1'b0);
        build_expect(20, 12'h300, 3, 1'b0, 1);
        run(20, 12'h300, 3, 1'b0, 1, 1'b0);

        // Start pulses during a busy drain must not alter it.
        build_expect(40, 12'h400, 8, 1'b0, 0);
        run(40, 12'h400, 8, 1'b0, 0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            int a, u, n, s;
            bit rl;
            fill_rand();
            ready_mode = int'($urandom_range(0, 1));
            a = int'($urandom_range(0, DEPTH - 1));
            u = int'($urandom_range(0, UB_DEPTH - 1));
            n = int'($urandom_range(1, 24));
            s = int'($urandom_range(0, 12));
            rl = 1'($urandom_range(0, 1));
            build_expect(a, u, n, rl, s);
            run(a, u, n, rl, s, 1'b0);
        end

        // Reset mid-drain after three writes.
        ready_mode = 0;
        build_expect(0, 12'h600, 8, 1'b0, 0);
        strobes = 0; writes = 0;
        @(negedge clk);
        start_i = 1'b1; rows_i = 9'd8; acc_start_addr_i = '0;
        ub_start_addr_wr_i = 12'h600; relu_en_i = 1'b0; shift_i = '0;
        @(negedge clk);
        start_i = 1'b0;
        wait_n = 0;
        while (writes < 3 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        chk("reach_three_writes", writes, 3);
        mon_en = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_read_strobe", read_accumulator_o, 1'b0);
        chk("midrst_wr_en", ub_wr_en_o, 1'b0);
        chk("midrst_acc_addr", accumulator_addr_rd_o, 0);
        chk("midrst_ub_addr", ub_addr_wr_o, 0);
        chk("midrst_ub_data", ub_data_wr_o, 0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_done", done_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ub_wr_en_o || read_accumulator_o || busy_o) stray++;
        end
        chk("no_activity_after_reset", stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
